// File: rtl/rsp_merger.sv
// -----------------------------------------------------------------------------
// rsp_merger
//
// Read-response merger on the DRAM controller return path. The command
// splitter upstream may break one read command into two downstream commands
// at a 2KB page boundary. This block keeps the split code of every issued
// downstream read in a small tag FIFO. It forwards the read beats upstream and
// hides the `last` flag of a first split piece, so upstream sees one burst with
// a single `last` per original command.
//
// Optional feature macro: RSP_MERGER_OUT_REG_EN
//   defined     -> upstream outputs go through a 2-entry spill register
//                  (full throughput, one cycle of added latency)
//   not defined -> purely combinational beat path, zero latency
//
// Parameters:
//   DataWidth     width of one read data beat
//   TagDepth      number of outstanding downstream reads tracked (power of 2, >=2)
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   tag_valid_i    downstream read command handshook this cycle
//   tag_ready_o    tag FIFO can accept a tag
//   tag_split_i    split code: 00 unsplit, 01 first piece, 10 second piece
//   rsp_valid_i    downstream read beat valid
//   rsp_ready_o    downstream read beat accepted
//   rsp_data_i     downstream beat data
//   rsp_last_i     last beat of one downstream command
//   rsp_valid_o    upstream beat valid
//   rsp_ready_i    upstream ready
//   rsp_data_o     upstream beat data
//   rsp_last_o     last beat of the original upstream command
//   outstanding_o  number of tags currently held
// -----------------------------------------------------------------------------
module rsp_merger #(
    parameter int unsigned DataWidth = 256,
    parameter int unsigned TagDepth  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          tag_valid_i,
    output logic                          tag_ready_o,
    input  logic [1:0]                    tag_split_i,
    input  logic                          rsp_valid_i,
    output logic                          rsp_ready_o,
    input  logic [DataWidth-1:0]          rsp_data_i,
    input  logic                          rsp_last_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DataWidth-1:0]          rsp_data_o,
    output logic                          rsp_last_o,
    output logic [$clog2(TagDepth):0]     outstanding_o
);

    localparam int unsigned PtrW = $clog2(TagDepth);
    localparam int unsigned CntW = PtrW + 1;

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    logic [1:0]      tag_mem [TagDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    logic            full;
    logic            push;
    logic            pop;
    logic            h_valid;
    logic [1:0]      h;

    // Readiness depends on fullness only; a pop in the same cycle does not
    // make room for a push.
    assign full        = (count == CntW'(TagDepth));
    assign tag_ready_o = ~full;
    assign push        = tag_valid_i & ~full;
    assign h_valid     = (count != '0);
    assign h           = tag_mem[rd_ptr];
    assign pop         = rsp_valid_i & rsp_ready_o & rsp_last_i;

    assign outstanding_o = count;

    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= tag_split_i;
        end
    end

    // Pointers wrap naturally because TagDepth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (pop && !push) begin
                count <= count - CntW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Masked beat stream
    // ------------------------------------------------------------------
    // The last beat of a first split piece (01) is hidden; code 11 behaves
    // like 00. Gating with h_valid keeps the stream quiet on an empty FIFO.
    logic                 m_valid;
    logic [DataWidth-1:0] m_data;
    logic                 m_last;

    assign m_valid = rsp_valid_i & h_valid;
    assign m_data  = rsp_data_i;
    assign m_last  = rsp_last_i & h_valid & (h != 2'b01);

`ifdef RSP_MERGER_OUT_REG_EN
    // ------------------------------------------------------------------
    // 2-entry spill register: entry a drives the outputs, entry b catches
    // a beat accepted while a is stalled. Ready is registered (~b_full), so
    // there is no combinational path from rsp_ready_i to rsp_ready_o.
    // ------------------------------------------------------------------
    logic                 a_full;
    logic                 b_full;
    logic [DataWidth-1:0] a_data;
    logic [DataWidth-1:0] b_data;
    logic                 a_last;
    logic                 b_last;
    logic                 spill_ready;
    logic                 in_fire;
    logic                 out_fire;

    assign spill_ready = ~b_full;
    assign in_fire     = m_valid & spill_ready;
    assign out_fire    = a_full & rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
            a_data <= '0;
            b_data <= '0;
            a_last <= 1'b0;
            b_last <= 1'b0;
        end else if (b_full) begin
            // No input is accepted while b holds a beat.
            if (out_fire) begin
                a_data <= b_data;
                a_last <= b_last;
                b_full <= 1'b0;
            end
        end else if (in_fire && a_full && !out_fire) begin
            b_data <= m_data;
            b_last <= m_last;
            b_full <= 1'b1;
        end else if (in_fire) begin
            a_data <= m_data;
            a_last <= m_last;
            a_full <= 1'b1;
        end else if (out_fire) begin
            a_full <= 1'b0;
        end
    end

    assign rsp_ready_o = spill_ready & h_valid;
    assign rsp_valid_o = a_full;
    assign rsp_data_o  = a_data;
    assign rsp_last_o  = a_last;
`else
    assign rsp_ready_o = rsp_ready_i & h_valid;
    assign rsp_valid_o = m_valid;
    assign rsp_data_o  = m_data;
    assign rsp_last_o  = m_last;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            assert (tag_split_i != 2'b11)
            else $error("rsp_merger: illegal split code 11 pushed");
        end
    end
`endif

endmodule

// File: doc/rsp_merger.md
# rsp_merger

Read-response merger on the DRAM controller return path, at the opposite end from the command splitter. The splitter may turn one upstream read command into two downstream commands at a 2KB page boundary. This block tracks the split code of every issued downstream read command and forwards downstream read beats upstream, masking the `last` flag of the first split piece. Upstream therefore sees exactly one burst with exactly one `last` per original command.

## Interface
Parameters:
- `DataWidth`, 256, width of one read data beat
- `TagDepth`, 4, number of outstanding downstream read commands tracked; power of two, ≥2

Ports:
- `clk_i`  in  1  clock; one clock domain
- `rst_ni`  in  1  reset, asynchronous, active-low
- `tag_valid_i`  in  1  a downstream read command handshook this cycle
- `tag_ready_o`  out  1  tag FIFO can accept a tag
- `tag_split_i`  in  2  split code of that command: 00 unsplit, 01 first piece, 10 second piece
- `rsp_valid_i`  in  1  downstream read beat valid
- `rsp_ready_o`  out  1  downstream read beat accepted
- `rsp_data_i`  in  DataWidth  downstream beat data
- `rsp_last_i`  in  1  last beat of one downstream command
- `rsp_valid_o`  out  1  upstream beat valid
- `rsp_ready_i`  in  1  upstream ready
- `rsp_data_o`  out  DataWidth  upstream beat data
- `rsp_last_o`  out  1  last beat of the original upstream command
- `outstanding_o`  out  $clog2(TagDepth)+1  tags currently held

## Operation
- Tag FIFO: circular buffer of TagDepth × 2 bits, with read/write pointers and an occupancy counter.
  - Push on `tag_valid_i && tag_ready_o`.
  - `tag_ready_o = ~full`. A pop in the same cycle does not free a slot for the push.
- Head tag `h` is valid when occupancy ≠ 0.
- Beat forwarding (combinational, zero latency):
  - `rsp_valid_o = rsp_valid_i && h_valid`
  - `rsp_ready_o = rsp_ready_i && h_valid`
  - `rsp_data_o = rsp_data_i`
  - `rsp_last_o = rsp_last_i && (h != 01)`
- Pop: on an accepted beat (`rsp_valid_i && rsp_ready_o`) with `rsp_last_i = 1`, pop the head tag.
- Empty FIFO: no beat is accepted or presented. A beat arriving in the same cycle as the first push waits one cycle.
- Split pairs need no extra state. The FIFO preserves order, so the 01 tag is always followed by its 10 tag, and the data path runs back-to-back across the piece boundary.
- Tag code 11 is illegal. It is pushed and treated as 00. A simulation assertion fires (`ifndef SYNTHESIS`).
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Pointers wrap modulo TagDepth.

## Timing
- Reset values: pointers 0, occupancy 0.
  - `tag_ready_o` = 1
  - `rsp_ready_o` = 0, `rsp_valid_o` = 0, `rsp_last_o` = 0
  - `outstanding_o` = 0
  - `rsp_data_o` follows `rsp_data_i`
- A pushed tag is visible at the head the cycle after the push.
- Throughput: one beat per cycle while tags are available.
- Reset mid-burst drops all tags and in-flight state immediately. Upstream and downstream are reset together.
- Overflow by upstream is impossible: the command issuer must stall on `tag_ready_o = 0`.

## Configuration
- `RSP_MERGER_OUT_REG_EN` defined:
  - The upstream outputs (`rsp_valid_o`, `rsp_data_o`, `rsp_last_o`) pass through a 2-entry spill register fed by the masked stream.
  - Full throughput, exactly 1 cycle of added latency.
  - `rsp_ready_o = spill_ready && h_valid`.
  - Spill register resets empty.
- Not defined: combinational path exactly as in Operation, zero latency.

## Test plan
- Push 00, then send 4 beats with last on beat 4 → 4 beats upstream with `rsp_last_o` only on beat 4; `outstanding_o` goes 1→0.
- Push 01 then 10, then send 3 beats (last) + 5 beats (last) back-to-back → 8 contiguous upstream beats, `rsp_last_o` only on beat 8; two pops.
- Empty FIFO with `rsp_valid_i = 1` → `rsp_ready_o = 0` and `rsp_valid_o = 0` until the cycle after a 00 push, then the beat is forwarded.
- Fill 4 tags with no beats → `tag_ready_o = 0`. A push+pop in the same cycle while full still rejects the push; `outstanding_o` reads 3 afterwards.
- `rsp_ready_i` toggling 1/0 every cycle on a split 01/10 pair → no beat lost or duplicated, data order preserved, single last.
- Assert `rst_ni` low in the middle of the second split piece → all outputs at reset values asynchronously; after release, a new 00 command merges correctly.
